ps2_scancode_rx: RTL

//  Receives PS/2 keyboard frames on the DE1 PS/2 port and decodes scan codes.

---
 rtl/ps2_scancode_rx.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: filters the pins, decodes frames and prefixes,
// and holds the last scan code plus the last make code for the hex display.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] code_out,
  output logic       code_valid,
  output logic       is_ext,
  output logic       is_break,
  output logic       frame_err,
  output logic [3:0] hex_hi,
  output logic [3:0] hex_lo
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic          filt, filt_d;
  logic [FW-1:0] flt_cnt;
  logic          fall;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_q, par_n;
  logic [TW-1:0] to_cnt;
  logic          frame_ok, frame_bad, timeout;

  logic          ext_pend, brk_pend;

  // Two-flop synchronisers; reset to the idle (high) bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // Clock glitch filter: a new level must persist FILTER_LEN samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt    <= 1'b1;
      filt_d  <= 1'b1;
      flt_cnt <= '0;
    end else begin
      filt_d <= filt;
      if (clk_s2 == filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        filt    <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall = filt_d & ~filt;

  // Frame state register and bit storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par_q   <= par_n;
    end
  end

  // Gap watchdog: reloads on every fall, idles at zero in IDLE.
  always_ff @(posedge clk) begin
    if (rst || fall || state == IDLE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Next-state logic; a fall takes priority over the watchdog.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par_q;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    timeout   = 1'b0;
    if (fall) begin
      unique case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end
        DATA: begin
          shreg_n   = {dat_s2, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_n = PARITY;
          end
        end
        PARITY: begin
          par_n   = dat_s2;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if ((^{shreg, par_q}) && dat_s2) begin
            frame_ok = 1'b1;
          end else begin
            frame_bad = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE &&
                 to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      timeout = 1'b1;
      state_n = IDLE;
    end
  end

  // Byte handling: prefixes arm flags, other bytes publish a code.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_out   <= '0;
      code_valid <= 1'b0;
      is_ext     <= 1'b0;
      is_break   <= 1'b0;
      frame_err  <= 1'b0;
      hex_hi     <= '0;
      hex_lo     <= '0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (frame_ok) begin
        if (shreg == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          code_out   <= shreg;
          code_valid <= 1'b1;
          is_ext     <= ext_pend;
          is_break   <= brk_pend;
          ext_pend   <= 1'b0;
          brk_pend   <= 1'b0;
          if (!brk_pend) begin
            hex_hi <= shreg[7:4];
            hex_lo <= shreg[3:0];
          end
        end
      end else if (frame_bad || timeout) begin
        frame_err <= 1'b1;
        ext_pend  <= 1'b0;
        brk_pend  <= 1'b0;
      end
    end
  end

endmodule
